// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the round-robin grant consumer:
//   - NREQ            : number of requestors behind the arbiter
//   - xfer_state_e    : burst FSM states (IDLE, XFER, DONE)
//   - onehot_to_idx() : binary index of a one-hot grant vector
//   - is_onehot()     : legality check for a grant vector
// ---------------------------------------------------------------------------
package rr_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_e;

  // Only meaningful for a one-hot input; returns 0 for an all-zero vector.
  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [NREQ-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/rr_gnt_stats.sv
// ---------------------------------------------------------------------------
// rr_gnt_stats
// Per-requestor grant counters. One 16-bit saturating counter per requestor,
// bumped on every burst capture for that requestor; read back
// combinationally through a select.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : capture pulse (one cycle per accepted grant)
//   inc_idx    : requestor index being captured
//   sel        : requestor whose counter is presented on cnt
//   cnt        : selected counter value
// ---------------------------------------------------------------------------
module rr_gnt_stats
  import rr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic [1:0]  inc_idx,
  input  logic [1:0]  sel,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (inc && (cnt_q[inc_idx] != 16'hFFFF)) begin
      cnt_q[inc_idx] <= cnt_q[inc_idx] + 16'd1;
    end
  end

  assign cnt = cnt_q[sel];

endmodule

// File: rtl/rr_gnt_xfer.sv
// ---------------------------------------------------------------------------
// rr_gnt_xfer
// Consumes the registered one-hot grant of a 4-requestor round-robin arbiter,
// latches the winner as owner and streams BURST beats of its payload onto a
// single valid/ready channel, then pulses ack[owner] for one cycle.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_valid,
// out_data, out_last and out_src are held unchanged.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   en                : accept enable for new grants (ignored mid-burst)
//   gnt[3:0]          : one-hot grant from the arbiter
//   req_data[4*DW-1:0]: requestor payloads, requestor i at [i*DW +: DW]
//   out_valid/out_data/out_ready : output beat channel
//   out_src[1:0]      : current owner index (held until the next capture)
//   out_last          : final beat of the burst
//   ack[3:0]          : one-cycle burst-complete pulse to the owner
//   busy              : burst in flight (XFER or DONE)
//   err               : sticky flag, multi-hot grant seen while accepting
//   stat_sel/stat_cnt : grant-count read port
//
// Optional feature macro: RR_GNT_STATS_EN builds the per-requestor grant
// counters; without it stat_cnt reads 0.
// ---------------------------------------------------------------------------
module rr_gnt_xfer
  import rr_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NREQ-1:0]    gnt,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic [1:0]         out_src,
  output logic               out_last,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic               err,
  input  logic [1:0]         stat_sel,
  output logic [15:0]        stat_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  // FSM state, kept as a named signal so checkers can bind to it.
  xfer_state_e state;
  logic [7:0]  beat;

  logic [1:0]    cap_idx;
  logic [DW-1:0] cap_data;
  logic [DW-1:0] owner_data;
  logic          capture;

  assign cap_idx    = onehot_to_idx(gnt);
  assign cap_data   = req_data[cap_idx*DW +: DW];
  assign owner_data = req_data[out_src*DW +: DW];
  assign capture    = (state == IDLE) && en && is_onehot(gnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (capture) begin
            out_src   <= cap_idx;
            out_data  <= cap_data;
            beat      <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            // A single-beat burst is already on its last beat.
            out_last  <= (LAST_BEAT == 8'd0);
            state     <= XFER;
          end else if (en && (gnt != '0)) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          if (out_ready) begin
            out_data <= owner_data;
            if (beat == LAST_BEAT) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              ack       <= 4'b0001 << out_src;
              state     <= DONE;
            end else begin
              beat     <= beat + 8'd1;
              out_last <= ((beat + 8'd1) == LAST_BEAT);
            end
          end
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_GNT_STATS_EN
  rr_gnt_stats u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (capture),
    .inc_idx (cap_idx),
    .sel     (stat_sel),
    .cnt     (stat_cnt)
  );
`else
  logic unused_stat;
  assign unused_stat = ^stat_sel;
  assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_rr_gnt_xfer.sv
// ---------------------------------------------------------------------------
// tb_rr_gnt_xfer
// Directed bench for rr_gnt_xfer (DW=8, BURST=4). Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at that same point,
// so every sample reflects the registered state of the current cycle.
// ---------------------------------------------------------------------------
module tb_rr_gnt_xfer;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [3:0]    gnt;
  logic [4*DW-1:0] req_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    out_src;
  logic          out_last;
  logic [3:0]    ack;
  logic          busy;
  logic          err;
  logic [1:0]    stat_sel;
  logic [15:0]   stat_cnt;

  int total = 0;
  int bad   = 0;

  rr_gnt_xfer #(.DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .gnt       (gnt),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_last  (out_last),
    .ack       (ack),
    .busy      (busy),
    .err       (err),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One full burst with out_ready held high. The grant is replaced by its
  // multi-hot complement during XFER: the owner must not change and err must
  // stay clear because gnt is ignored mid-burst.
  task automatic run_burst(input logic [3:0] g, input logic [1:0] idx, input logic [7:0] d);
    gnt = g; en = 1'b1; out_ready = 1'b1;
    step();
    gnt = ~g;
    for (int b = 0; b < BURST; b++) begin
      chk("xfer_valid", out_valid, 1);
      chk("xfer_src",   out_src, idx);
      chk("xfer_data",  out_data, d);
      chk("xfer_last",  out_last, (b == BURST - 1));
      chk("xfer_busy",  busy, 1);
      chk("xfer_ack",   ack, 0);
      step();
    end
    gnt = 4'b0000;
    chk("done_valid", out_valid, 0);
    chk("done_ack",   ack, g);
    chk("done_busy",  busy, 1);
    chk("done_last",  out_last, 0);
    step();
    chk("idle_ack",   ack, 0);
    chk("idle_busy",  busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_src",   out_src, idx);
    chk("idle_err",   err, 0);
  endtask

  logic [5:0] rdy_pat;
  int hs;
  int ack_cnt;
  logic [7:0] prev_data;

  initial begin
    rst_n = 1'b0; en = 1'b0; gnt = 4'b0000; out_ready = 1'b0; stat_sel = 2'd0;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h3C};

    // reset state
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_src",   out_src, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_ack",   ack, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_err",   err, 0);
    chk("rst_stat",  stat_cnt, 0);
    rst_n = 1'b1;
    step();

    // basic burst from requestor 2, payload A5
    run_burst(4'b0100, 2'd2, 8'hA5);

    // multi-hot grant in IDLE: sticky err, no transfer
    gnt = 4'b0011; en = 1'b1;
    step();
    gnt = 4'b0000;
    chk("mh_err",   err, 1);
    chk("mh_valid", out_valid, 0);
    chk("mh_ack",   ack, 0);
    step(); step();
    chk("mh_err_sticky", err, 1);
    chk("mh_valid2", out_valid, 0);
    chk("mh_ack2",   ack, 0);

    // stalled burst from requestor 0: ready pattern 1,0,0,1,1,1
    rdy_pat = 6'b111001; // bit k is ready in XFER cycle k
    gnt = 4'b0001; en = 1'b1;
    step();
    gnt = 4'b0000;
    hs = 0;
    ack_cnt = 0;
    prev_data = out_data;
    for (int k = 0; k < 10; k++) begin
      out_ready = (k < 6) ? rdy_pat[k] : 1'b1;
      if (ack != 4'b0000) ack_cnt++;
      if (k < 6) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data",  out_data, 8'h3C);
        chk("stall_hold",  out_data, prev_data);
        chk("stall_last",  out_last, (hs == BURST - 1));
        if (out_ready) hs++;
      end
      if (k == 6) begin
        chk("stall_ack", ack, 4'b0001);
        chk("stall_valid_done", out_valid, 0);
      end
      prev_data = out_data;
      step();
    end
    chk("stall_hs_cnt",  hs, 4);
    chk("stall_ack_cnt", ack_cnt, 1);
    chk("stall_idle",    busy, 0);

    // reset on the 2nd beat of a burst from requestor 1
    req_data = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
    gnt = 4'b0010; en = 1'b1; out_ready = 1'b1;
    step();
    gnt = 4'b0000;
    chk("mr_beat1_valid", out_valid, 1);
    chk("mr_beat1_src",   out_src, 1);
    step();
    chk("mr_beat2_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy",  busy, 0);
    chk("mr_ack",   ack, 0);
    chk("mr_src",   out_src, 0);
    chk("mr_data",  out_data, 0);
    chk("mr_err",   err, 0);
    step();
    chk("mr_ack_after", ack, 0);
    chk("mr_busy_after", busy, 0);
    run_burst(4'b1000, 2'd3, 8'hC3);

    // en low: grant is not captured
    gnt = 4'b0001; en = 1'b0;
    step(); step();
    chk("en0_valid", out_valid, 0);
    chk("en0_busy",  busy, 0);
    chk("en0_src",   out_src, 3);
    chk("en0_err",   err, 0);
    gnt = 4'b0000; en = 1'b1;
    step();

    // owner held while gnt changes during XFER
    run_burst(4'b0100, 2'd2, 8'hA5);

    // grant counters: requestor 1 three times
    run_burst(4'b0010, 2'd1, 8'h5A);
    run_burst(4'b0010, 2'd1, 8'h5A);
    run_burst(4'b0010, 2'd1, 8'h5A);
    stat_sel = 2'd1;
    #1;
`ifdef RR_GNT_STATS_EN
    chk("stat_req1", stat_cnt, 3);
`else
    chk("stat_req1", stat_cnt, 0);
`endif
    stat_sel = 2'd0;
    #1;
    chk("stat_req0", stat_cnt, 0);
    stat_sel = 2'd2;
    #1;
`ifdef RR_GNT_STATS_EN
    chk("stat_req2", stat_cnt, 1);
`else
    chk("stat_req2", stat_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
